// File: rtl/ped_signal_ctrl_if.sv
// Interface for the pedestrian controller: vehicle lamps and button in, pedestrian lamps and status out.
interface ped_signal_ctrl_if #(parameter int CNT_W = 4);
    logic             Red;
    logic             Green;
    logic             Yellow;
    logic             ped_req;
    logic             Walk;
    logic             DontWalk;
    logic [CNT_W-1:0] countdown;
    logic             req_pend;
    logic             req_ack;

    modport master (
        output Red, Green, Yellow, ped_req,
        input  Walk, DontWalk, countdown, req_pend, req_ack
    );

    modport slave (
        input  Red, Green, Yellow, ped_req,
        output Walk, DontWalk, countdown, req_pend, req_ack
    );
endinterface

// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller: grants Walk then flashing clearance on a Red rising edge
// when a button request is pending; aborts the crossing whenever Red is lost or lights are invalid.
module ped_signal_ctrl #(
    parameter int WALK_CYCLES  = 2,
    parameter int FLASH_CYCLES = 2,
    parameter int CNT_W        = 4
) (
    input  logic               clk,
    input  logic               rst,
    ped_signal_ctrl_if.slave   bus
);
    localparam int T = WALK_CYCLES + FLASH_CYCLES;

    typedef enum logic [1:0] {IDLE, WALK, FLASH} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             req_pend, req_pend_nx;
    logic             req_ack, red_q;
    logic             red_rise, lights_ok, abort, grant;

    assign red_rise  = bus.Red & ~red_q;
    assign lights_ok = ({bus.Red, bus.Green, bus.Yellow} == 3'b100) ||
                       ({bus.Red, bus.Green, bus.Yellow} == 3'b010) ||
                       ({bus.Red, bus.Green, bus.Yellow} == 3'b001);
    assign abort     = ~bus.Red | ~lights_ok;
    // Grants happen only on the rising edge of Red, so a late request waits for the next red phase.
    assign grant     = (state == IDLE) & red_rise & lights_ok & (req_pend | bus.ped_req);

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        req_pend_nx = req_pend;
        if (grant)
            req_pend_nx = 1'b0;
        else if (bus.ped_req)
            req_pend_nx = 1'b1;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nx = WALK;
                    cnt_nx   = CNT_W'(T - 1);
                end
            end
            WALK: begin
                if (abort) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_W'(FLASH_CYCLES)) begin
                    state_nx = FLASH;
                    cnt_nx   = CNT_W'(FLASH_CYCLES - 1);
                end else begin
                    cnt_nx   = cnt - CNT_W'(1);
                end
            end
            FLASH: begin
                if (abort) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx   = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            req_pend <= 1'b0;
            req_ack  <= 1'b0;
            red_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            req_pend <= req_pend_nx;
            req_ack  <= grant;
            red_q    <= bus.Red;
        end
    end

    // Lamp outputs follow Red combinationally so a walk indication never outlives the vehicle red.
    always_comb begin
        bus.Walk     = (state == WALK) & bus.Red;
        bus.DontWalk = ~bus.Walk;
        if (state == FLASH)
            bus.DontWalk = cnt[0] | ~bus.Red;
    end

    assign bus.countdown = (state == IDLE) ? '0 : cnt;
    assign bus.req_pend  = req_pend;
    assign bus.req_ack   = req_ack;
endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Scoreboarded bench: a driver pushes model-predicted outputs per cycle, a monitor pops and compares.
module tb_ped_signal_ctrl;
    localparam int WALK_CYCLES  = 2;
    localparam int FLASH_CYCLES = 2;
    localparam int CNT_W        = 4;
    localparam int T            = WALK_CYCLES + FLASH_CYCLES;

    typedef struct {
        logic             walk;
        logic             dw;
        logic [CNT_W-1:0] cd;
        logic             pend;
        logic             ack;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    ped_signal_ctrl_if #(.CNT_W(CNT_W)) bus ();

    ped_signal_ctrl #(
        .WALK_CYCLES (WALK_CYCLES),
        .FLASH_CYCLES(FLASH_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: a crossing is "elapsed cycles k since grant"; walk for the
    // first WALK_CYCLES of them, flashing clearance for the rest.
    bit m_cross, m_pend, m_ack, m_prev_red;
    int m_k;

    task automatic model_step(input logic r, g, y, req, rs);
        bit ok, rise, gnt;
        if (!rs) begin
            m_cross = 0; m_pend = 0; m_ack = 0; m_prev_red = 0; m_k = 0;
        end else begin
            ok   = (int'(r) + int'(g) + int'(y)) == 1;
            rise = r && !m_prev_red;
            gnt  = !m_cross && rise && ok && (m_pend || req);
            m_ack = gnt;
            if (gnt) m_pend = 0;
            else if (req) m_pend = 1;
            if (m_cross) begin
                if (!r || !ok) m_cross = 0;
                else begin
                    m_k++;
                    if (m_k == T) m_cross = 0;
                end
            end else if (gnt) begin
                m_cross = 1;
                m_k = 0;
            end
            m_prev_red = r;
        end
    endtask

    function automatic exp_t model_out(input logic r);
        exp_t e;
        int   cd;
        cd     = m_cross ? (T - 1 - m_k) : 0;
        e.cd   = CNT_W'(cd);
        e.walk = m_cross && (m_k < WALK_CYCLES) && r;
        if (m_cross && m_k >= WALK_CYCLES) e.dw = e.cd[0] | ~r;
        else e.dw = ~e.walk;
        e.pend = m_pend;
        e.ack  = m_ack;
        return e;
    endfunction

    // One clock: the model takes the edge with the inputs the DUT just sampled,
    // then new inputs are applied and this cycle's expected outputs queued.
    task automatic tick(input logic r, g, y, req, rs);
        @(posedge clk);
        model_step(bus.Red, bus.Green, bus.Yellow, bus.ped_req, rst);
        #1;
        bus.Red = r; bus.Green = g; bus.Yellow = y; bus.ped_req = req; rst = rs;
        sb_q.push_back(model_out(r));
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("Walk",      int'(bus.Walk),      int'(e.walk));
                chk("DontWalk",  int'(bus.DontWalk),  int'(e.dw));
                chk("countdown", int'(bus.countdown), int'(e.cd));
                chk("req_pend",  int'(bus.req_pend),  int'(e.pend));
                chk("req_ack",   int'(bus.req_ack),   int'(e.ack));
            end
        end
    end

    initial begin : driver
        logic [2:0] lamps;
        int         hold;
        rst = 1'b0;
        bus.Red = 0; bus.Green = 0; bus.Yellow = 0; bus.ped_req = 0;
        // reset, then idle lights
        repeat (3) tick(0, 0, 0, 0, 0);
        repeat (2) tick(0, 1, 0, 0, 1);
        // request in green, served on Red rise, red held 5 cycles
        tick(0, 1, 0, 1, 1);
        tick(0, 1, 0, 0, 1);
        repeat (5) tick(1, 0, 0, 0, 1);
        repeat (3) tick(0, 1, 0, 0, 1);
        // request on the same edge as red_rise
        tick(1, 0, 0, 1, 1);
        repeat (5) tick(1, 0, 0, 0, 1);
        repeat (2) tick(0, 1, 0, 0, 1);
        // request one cycle after red_rise waits for the next red
        tick(1, 0, 0, 0, 1);
        tick(1, 0, 0, 1, 1);
        repeat (4) tick(1, 0, 0, 0, 1);
        repeat (2) tick(0, 0, 1, 0, 1);
        repeat (6) tick(1, 0, 0, 0, 1);
        // Red drops after one walk cycle
        tick(0, 1, 0, 1, 1);
        tick(1, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 1);
        repeat (3) tick(0, 1, 0, 0, 1);
        // illegal lights during walk
        tick(0, 1, 0, 1, 1);
        tick(1, 0, 0, 0, 1);
        tick(1, 1, 0, 0, 1);
        repeat (2) tick(0, 1, 0, 0, 1);
        // reset during flash with a second request latched
        tick(0, 1, 0, 1, 1);
        tick(1, 0, 0, 0, 1);
        tick(1, 0, 0, 1, 1);
        tick(1, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 0);
        repeat (3) tick(1, 0, 0, 0, 1);
        repeat (2) tick(0, 1, 0, 0, 1);
        // randomized light phases, requests and occasional reset
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2:    lamps = 3'b010;
                3, 4:       lamps = 3'b001;
                5, 6, 7, 8: lamps = 3'b100;
                default:    lamps = 3'($urandom_range(0, 7));
            endcase
            hold = $urandom_range(1, 7);
            for (int h = 0; h < hold; h++)
                tick(lamps[2], lamps[1], lamps[0], ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 99) != 0));
        end
        repeat (3) tick(0, 1, 0, 0, 1);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
